// File: rtl/fb_pixel_fetch_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_pixel_fetch_pkg
// Shared video definitions for the frame-buffer pixel fetch path.
// Rev 1.0 - initial release
// ============================================================================
package fb_pixel_fetch_pkg;

    localparam int c_fb_width     = 240;
    localparam int c_fb_height    = 320;
    localparam int c_bram_latency = 2;
    localparam int c_pix_idx_w    = 17;
    localparam int c_addr_w       = c_pix_idx_w + 1;

    typedef enum logic [1:0] {
        SCALE_1X     = 2'b00,
        SCALE_1X_ALT = 2'b01,
        SCALE_4X2    = 2'b10,
        SCALE_2X2    = 2'b11
    } scale_e;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_ACKED   = 2'd2
    } swap_state_e;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_t;

    // Widen RGB565 to RGB888 by replicating the top bits into the new LSBs.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {px[15:11], px[15:13]};
        g = {px[10:5],  px[10:9]};
        b = {px[4:0],   px[4:2]};
        return {r, g, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_fetch_scale.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_pixel_fetch_scale
// Maps raster coordinates to frame-buffer coordinates and flags the in-range window.
// Rev 1.0 - initial release
// ============================================================================
module fb_pixel_fetch_scale
    import fb_pixel_fetch_pkg::*;
#(
    parameter int FB_WIDTH  = c_fb_width,
    parameter int FB_HEIGHT = c_fb_height
) (
    input  logic [1:0]  i_scale,
    input  logic [10:0] i_hcount,
    input  logic [9:0]  i_vcount,
    output logic [10:0] o_scaled_h,
    output logic [9:0]  o_scaled_v,
    output logic        o_in_range
);

    localparam logic [12:0] c_h_lim_1x = 13'(FB_WIDTH);
    localparam logic [12:0] c_h_lim_2x = 13'(2 * FB_WIDTH);
    localparam logic [12:0] c_h_lim_4x = 13'(4 * FB_WIDTH);
    localparam logic [11:0] c_v_lim_1x = 12'(FB_HEIGHT);
    localparam logic [11:0] c_v_lim_2x = 12'(2 * FB_HEIGHT);

    logic [12:0] w_h_ext;
    logic [11:0] w_v_ext;

    assign w_h_ext = {2'b00, i_hcount};
    assign w_v_ext = {2'b00, i_vcount};

    always_comb begin
        o_scaled_h = i_hcount;
        o_scaled_v = i_vcount;
        o_in_range = (w_h_ext < c_h_lim_1x) && (w_v_ext < c_v_lim_1x);
        case (i_scale)
            SCALE_4X2: begin
                o_scaled_h = {2'b00, i_hcount[10:2]};
                o_scaled_v = {1'b0, i_vcount[9:1]};
                o_in_range = (w_h_ext < c_h_lim_4x) && (w_v_ext < c_v_lim_2x);
            end
            SCALE_2X2: begin
                o_scaled_h = {1'b0, i_hcount[10:1]};
                o_scaled_v = {1'b0, i_vcount[9:1]};
                o_in_range = (w_h_ext < c_h_lim_2x) && (w_v_ext < c_v_lim_2x);
            end
            default: begin
                // 01 behaves exactly like 1x.
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fb_pixel_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_pixel_fetch
// Scaled frame-buffer read pipeline with double-buffer bank swap handshake.
// Rev 1.0 - initial release
// ============================================================================
module fb_pixel_fetch
    import fb_pixel_fetch_pkg::*;
#(
    parameter int FB_WIDTH     = c_fb_width,
    parameter int FB_HEIGHT    = c_fb_height,
    parameter int BRAM_LATENCY = c_bram_latency
) (
    input  logic                clk_pixel_in,
    input  logic                rst_n_in,
    input  logic [1:0]          scale_in,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                active_draw_in,
    input  logic                new_frame_in,
    input  logic                swap_req_in,
    input  logic [15:0]         bram_dout_in,
    output logic [c_addr_w-1:0] bram_addr_out,
    output logic                bram_en_out,
    output logic [7:0]          red_out,
    output logic [7:0]          green_out,
    output logic [7:0]          blue_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                active_draw_out,
    output logic                swap_ack_out,
    output logic                disp_bank_out
);

    localparam int c_pipe_depth = 2 + BRAM_LATENCY;

    logic [10:0]            w_scaled_h;
    logic [9:0]             w_scaled_v;
    logic                   w_in_range;
    logic                   w_fetch;
    logic [c_pix_idx_w-1:0] w_pix_idx;
    logic [23:0]            w_rgb;

    logic [c_addr_w-1:0]    r_bram_addr;
    logic                   r_bram_en;
    logic [BRAM_LATENCY-1:0] r_valid_d;
    sync_t                  r_sync [c_pipe_depth];
    logic [7:0]             r_red;
    logic [7:0]             r_green;
    logic [7:0]             r_blue;

    swap_state_e            r_swap_state;
    swap_state_e            w_swap_next;
    logic                   w_swap_fire;
    logic                   r_disp_bank;
    logic                   r_swap_ack;

    fb_pixel_fetch_scale #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_scale (
        .i_scale    (scale_in),
        .i_hcount   (hcount_in),
        .i_vcount   (vcount_in),
        .o_scaled_h (w_scaled_h),
        .o_scaled_v (w_scaled_v),
        .o_in_range (w_in_range)
    );

    assign w_fetch   = w_in_range && active_draw_in;
    assign w_pix_idx = c_pix_idx_w'(w_scaled_v) * c_pix_idx_w'(FB_WIDTH)
                     + c_pix_idx_w'(w_scaled_h);
    assign w_rgb     = rgb565_to_888(bram_dout_in);

    // Stage 1: address issue; the address register holds between fetches.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
        end else begin
            r_bram_en <= w_fetch;
            if (w_fetch) begin
                r_bram_addr <= {r_disp_bank, w_pix_idx};
            end
        end
    end

    // Valid flag follows the read data through the BRAM latency.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid_d <= '0;
        end else begin
            r_valid_d[0] <= r_bram_en;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                r_valid_d[i] <= r_valid_d[i-1];
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < c_pipe_depth; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= '{hsync: hsync_in, vsync: vsync_in, active: active_draw_in};
            for (int i = 1; i < c_pipe_depth; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_valid_d[BRAM_LATENCY-1]) begin
            r_red   <= w_rgb[23:16];
            r_green <= w_rgb[15:8];
            r_blue  <= w_rgb[7:0];
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    // A request that drops before a frame boundary is abandoned silently.
    always_comb begin
        w_swap_next = r_swap_state;
        w_swap_fire = 1'b0;
        case (r_swap_state)
            SWAP_IDLE: begin
                if (swap_req_in) begin
                    w_swap_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (!swap_req_in) begin
                    w_swap_next = SWAP_IDLE;
                end else if (new_frame_in) begin
                    w_swap_fire = 1'b1;
                    w_swap_next = SWAP_ACKED;
                end
            end
            SWAP_ACKED: begin
                if (!swap_req_in) begin
                    w_swap_next = SWAP_IDLE;
                end
            end
            default: begin
                w_swap_next = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_swap_state <= SWAP_IDLE;
            r_disp_bank  <= 1'b0;
            r_swap_ack   <= 1'b0;
        end else begin
            r_swap_state <= w_swap_next;
            r_disp_bank  <= r_disp_bank ^ w_swap_fire;
            r_swap_ack   <= w_swap_fire;
        end
    end

    assign bram_addr_out   = r_bram_addr;
    assign bram_en_out     = r_bram_en;
    assign red_out         = r_red;
    assign green_out       = r_green;
    assign blue_out        = r_blue;
    assign hsync_out       = r_sync[c_pipe_depth-1].hsync;
    assign vsync_out       = r_sync[c_pipe_depth-1].vsync;
    assign active_draw_out = r_sync[c_pipe_depth-1].active;
    assign swap_ack_out    = r_swap_ack;
    assign disp_bank_out   = r_disp_bank;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_fb_pixel_fetch
// Directed vector bench for fb_pixel_fetch with a 2-cycle BRAM model.
// Rev 1.0 - initial release
// ============================================================================
module tb_fb_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  scale;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        hs, vs, ad, nf, sreq;
    logic [15:0] dout;
    logic [17:0] addr;
    logic        en;
    logic [7:0]  red, green, blue;
    logic        hs_o, vs_o, ad_o, ack, bank;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fb_pixel_fetch dut (
        .clk_pixel_in    (clk),
        .rst_n_in        (rst_n),
        .scale_in        (scale),
        .hcount_in       (hcnt),
        .vcount_in       (vcnt),
        .hsync_in        (hs),
        .vsync_in        (vs),
        .active_draw_in  (ad),
        .new_frame_in    (nf),
        .swap_req_in     (sreq),
        .bram_dout_in    (dout),
        .bram_addr_out   (addr),
        .bram_en_out     (en),
        .red_out         (red),
        .green_out       (green),
        .blue_out        (blue),
        .hsync_out       (hs_o),
        .vsync_out       (vs_o),
        .active_draw_out (ad_o),
        .swap_ack_out    (ack),
        .disp_bank_out   (bank)
    );

    // Memory contents are a fixed function of the address; 490 in bank 0 reads 0xF800.
    function automatic logic [15:0] bram_word(input logic [17:0] a);
        return a[15:0] ^ 16'hF9EA ^ {a[17:16], 14'd0};
    endfunction

    function automatic logic [23:0] exp888(input logic [15:0] d);
        logic [7:0] r, g, b;
        r = {d[15:11], 3'b000} | {5'b00000, d[15:13]};
        g = {d[10:5], 2'b00}   | {6'b000000, d[10:9]};
        b = {d[4:0], 3'b000}   | {5'b00000, d[4:2]};
        return {r, g, b};
    endfunction

    logic [15:0] r_m1 = '0;
    logic [15:0] r_m2 = '0;
    always @(posedge clk) begin
        r_m1 <= bram_word(addr);
        r_m2 <= r_m1;
    end
    assign dout = r_m2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  scale;
        logic [10:0] h;
        logic [9:0]  v;
        logic        act;
        logic        hs;
        logic        vs;
        logic [16:0] idx;
        logic        en;
    } vec_t;

    vec_t        vecs [12];
    logic [23:0] exp_rgb;
    logic [23:0] st_rgb [10];
    logic        st_hs  [10];
    logic        st_vs  [10];
    logic        st_ad  [10];

    initial begin
        vecs[0]  = '{2'b00, 11'd10,  10'd2,   1'b1, 1'b1, 1'b0, 17'd490,   1'b1};
        vecs[1]  = '{2'b00, 11'd239, 10'd319, 1'b1, 1'b0, 1'b1, 17'd76799, 1'b1};
        vecs[2]  = '{2'b00, 11'd240, 10'd0,   1'b1, 1'b1, 1'b1, 17'd76799, 1'b0};
        vecs[3]  = '{2'b11, 11'd479, 10'd639, 1'b1, 1'b0, 1'b0, 17'd76799, 1'b1};
        vecs[4]  = '{2'b11, 11'd480, 10'd0,   1'b1, 1'b1, 1'b0, 17'd76799, 1'b0};
        vecs[5]  = '{2'b10, 11'd100, 10'd5,   1'b1, 1'b0, 1'b1, 17'd505,   1'b1};
        vecs[6]  = '{2'b10, 11'd960, 10'd0,   1'b1, 1'b1, 1'b1, 17'd505,   1'b0};
        vecs[7]  = '{2'b01, 11'd5,   10'd1,   1'b1, 1'b0, 1'b0, 17'd245,   1'b1};
        vecs[8]  = '{2'b11, 11'd20,  10'd9,   1'b1, 1'b1, 1'b0, 17'd970,   1'b1};
        vecs[9]  = '{2'b00, 11'd10,  10'd2,   1'b0, 1'b0, 1'b1, 17'd970,   1'b0};
        vecs[10] = '{2'b00, 11'd0,   10'd320, 1'b1, 1'b1, 1'b1, 17'd970,   1'b0};
        vecs[11] = '{2'b10, 11'd3,   10'd1,   1'b1, 1'b0, 1'b0, 17'd0,     1'b1};

        rst_n = 1'b0; scale = 2'b00; hcnt = '0; vcnt = '0;
        hs = 1'b0; vs = 1'b0; ad = 1'b0; nf = 1'b0; sreq = 1'b0;
        step(); step();
        chk("rst addr", 32'(addr), 32'd0);
        chk("rst en", 32'(en), 32'd0);
        chk("rst rgb", 32'({red, green, blue}), 32'd0);
        chk("rst sync", 32'({hs_o, vs_o, ad_o}), 32'd0);
        chk("rst ack/bank", 32'({ack, bank}), 32'd0);
        rst_n = 1'b1;
        step();

        // Isolated pixels: stage-1 address/enable, then colour and sync 4 edges after input.
        for (int i = 0; i < 12; i++) begin
            scale = vecs[i].scale; hcnt = vecs[i].h; vcnt = vecs[i].v;
            ad = vecs[i].act; hs = vecs[i].hs; vs = vecs[i].vs;
            step();
            chk($sformatf("v%0d addr", i), 32'(addr), 32'({1'b0, vecs[i].idx}));
            chk($sformatf("v%0d en", i), 32'(en), 32'(vecs[i].en));
            ad = 1'b0; hs = 1'b0; vs = 1'b0;
            step(); step(); step();
            exp_rgb = vecs[i].en ? exp888(bram_word({1'b0, vecs[i].idx})) : 24'd0;
            chk($sformatf("v%0d rgb", i), 32'({red, green, blue}), 32'(exp_rgb));
            chk($sformatf("v%0d hsync", i), 32'(hs_o), 32'(vecs[i].hs));
            chk($sformatf("v%0d vsync", i), 32'(vs_o), 32'(vecs[i].vs));
            chk($sformatf("v%0d active", i), 32'(ad_o), 32'(vecs[i].act));
            if (i == 0) begin
                chk("v0 red FF", 32'(red), 32'h0000_00FF);
                chk("v0 green 0", 32'(green), 32'd0);
                chk("v0 blue 0", 32'(blue), 32'd0);
            end
        end

        // Back-to-back stream: outputs must track inputs exactly 4 cycles later.
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                scale = 2'b00; hcnt = 11'(50 + c); vcnt = 10'd7;
                ad = (c != 5); hs = (c == 3); vs = (c == 6);
                st_ad[c] = ad; st_hs[c] = hs; st_vs[c] = vs;
                st_rgb[c] = ad ? exp888(bram_word(18'(1730 + c))) : 24'd0;
            end else begin
                ad = 1'b0; hs = 1'b0; vs = 1'b0;
            end
            step();
            if (c >= 3) begin
                chk($sformatf("s%0d rgb", c - 3), 32'({red, green, blue}), 32'(st_rgb[c-3]));
                chk($sformatf("s%0d hsync", c - 3), 32'(hs_o), 32'(st_hs[c-3]));
                chk($sformatf("s%0d vsync", c - 3), 32'(vs_o), 32'(st_vs[c-3]));
                chk($sformatf("s%0d active", c - 3), 32'(ad_o), 32'(st_ad[c-3]));
            end
        end

        // Swap on frame boundary; in-flight address keeps the old bank.
        sreq = 1'b1;
        step();
        scale = 2'b00; hcnt = 11'd10; vcnt = 10'd2; ad = 1'b1; nf = 1'b1;
        step();
        chk("swap ack", 32'(ack), 32'd1);
        chk("swap bank", 32'(bank), 32'd1);
        chk("swap old bank addr", 32'(addr), 32'h0000_01EA);
        nf = 1'b0;
        step();
        chk("swap ack drop", 32'(ack), 32'd0);
        chk("swap new bank addr", 32'(addr), 32'h0002_01EA);
        nf = 1'b1;
        step();
        chk("acked no retoggle", 32'(bank), 32'd1);
        chk("acked no ack", 32'(ack), 32'd0);
        nf = 1'b0; sreq = 1'b0; ad = 1'b0;
        step();

        // Request and frame start together: swap waits for the next frame.
        sreq = 1'b1; nf = 1'b1;
        step();
        chk("coincident no ack", 32'(ack), 32'd0);
        chk("coincident no swap", 32'(bank), 32'd1);
        nf = 1'b0;
        step();
        nf = 1'b1;
        step();
        chk("deferred ack", 32'(ack), 32'd1);
        chk("deferred swap", 32'(bank), 32'd0);
        nf = 1'b0; sreq = 1'b0;
        step();

        // Request withdrawn while pending.
        sreq = 1'b1;
        step();
        sreq = 1'b0;
        step();
        nf = 1'b1;
        step();
        chk("withdrawn no ack", 32'(ack), 32'd0);
        chk("withdrawn no swap", 32'(bank), 32'd0);
        nf = 1'b0;

        // Reach PENDING with bank 1 and pixels in flight, then reset mid-cycle.
        sreq = 1'b1;
        step();
        nf = 1'b1;
        step();
        chk("pre-reset bank", 32'(bank), 32'd1);
        nf = 1'b0; sreq = 1'b0;
        step();
        sreq = 1'b1;
        step();
        hcnt = 11'd10; vcnt = 10'd2; ad = 1'b1; hs = 1'b1;
        step(); step(); step(); step();
        chk("pre-reset rgb", 32'({red, green, blue}), 32'(exp888(bram_word(18'h2_01EA))));
        chk("pre-reset hsync", 32'(hs_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rgb", 32'({red, green, blue}), 32'd0);
        chk("async rst sync", 32'({hs_o, vs_o, ad_o}), 32'd0);
        chk("async rst bank", 32'(bank), 32'd0);
        chk("async rst addr/en", 32'({en, addr}), 32'd0);
        step();
        hs = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post-rst addr", 32'(addr), 32'h0000_01EA);
        nf = 1'b1;
        step();
        chk("post-rst ack", 32'(ack), 32'd1);
        chk("post-rst bank", 32'(bank), 32'd1);
        nf = 1'b0; ad = 1'b0;
        step();
        chk("post-rst not yet active", 32'(ad_o), 32'd0);
        chk("post-rst not yet rgb", 32'({red, green, blue}), 32'd0);
        step();
        chk("post-rst active", 32'(ad_o), 32'd1);
        chk("post-rst rgb", 32'({red, green, blue}), 32'h00FF_0000);
        sreq = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
